// File: rtl/psum_acc_pkg.sv
// Shared types and arithmetic for the psum accumulation stage.
// Holds the FSM encoding, psum limits and the per-column saturating add.
package psum_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int PSUM_BW = 16;
    localparam logic signed [PSUM_BW-1:0] PSUM_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
    localparam logic signed [PSUM_BW-1:0] PSUM_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

    // Operands arrive sign-extended to 32 bits; the result clamps to a bw-bit
    // signed range, so any psum width up to 31 bits shares this one helper.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int unsigned       bw);
        logic signed [32:0] sum;
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        sum = {a[31], a} + {b[31], b};
        hi  = (33'sd1 <<< (bw - 32'd1)) - 33'sd1;
        lo  = -(33'sd1 <<< (bw - 32'd1));
        if (sum > hi) begin
            return hi[31:0];
        end
        if (sum < lo) begin
            return lo[31:0];
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/psum_acc_if.sv
// OFIFO-side pop port, drain-side valid/ready port and job control for psum_acc.
// master = job controller / neighbours, slave = psum_acc.
interface psum_acc_if #(
    parameter int col     = 8,
    parameter int psum_bw = 16
);
    logic                     start;
    logic                     ofifo_o_valid;
    logic [col*psum_bw-1:0]   ofifo_out;
    logic                     ofifo_rd;
    logic [col*psum_bw-1:0]   out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     busy;
    logic                     done;

    modport master (
        output start, ofifo_o_valid, ofifo_out, out_ready,
        input  ofifo_rd, out_data, out_valid, busy, done
    );

    modport slave (
        input  start, ofifo_o_valid, ofifo_out, out_ready,
        output ofifo_rd, out_data, out_valid, busy, done
    );
endinterface

// File: rtl/psum_bank.sv
// depth x width register file: one write port, combinational accumulate read, registered drain read.
// Drain read forwards a same-cycle write so the entry edge into DRAIN sees the newest row.
module psum_bank #(
    parameter int width = 128,
    parameter int depth = 16,
    parameter int aw    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [aw-1:0]    wr_addr,
    input  logic [width-1:0] wr_dat,
    input  logic [aw-1:0]    rd_addr,
    output logic [width-1:0] rd_dat,
    input  logic             drd_en,
    input  logic [aw-1:0]    drd_addr,
    output logic [width-1:0] drd_dat
);

    logic [width-1:0] mem_q [depth];
    logic [width-1:0] drd_q;
    logic [width-1:0] drd_d;

    // Storage is deliberately not reset: pass 0 of every job overwrites each row.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem_q[rd_addr];

    always_comb begin
        drd_d = drd_q;
        if (drd_en) begin
            drd_d = (we && (wr_addr == drd_addr)) ? wr_dat : mem_q[drd_addr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drd_q <= '0;
        end else begin
            drd_q <= drd_d;
        end
    end

    assign drd_dat = drd_q;

endmodule

// File: rtl/psum_acc.sv
// Accumulates `passes` x `depth` OFIFO rows (saturating) then drains them; 1 row/cycle, registered drain.
// Pops only while OFIFO valid; drain holds out_data under !out_ready. Macro PSUM_ACC_RELU_EN clamps drained values at 0.
module psum_acc
    import psum_acc_pkg::*;
#(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 16,
    parameter int passes  = 9
) (
    input  logic       clk,
    input  logic       reset,
    psum_acc_if.slave  bus
);

    localparam int AW = (depth  > 1) ? $clog2(depth)  : 1;
    localparam int PW = (passes > 1) ? $clog2(passes) : 1;
    localparam int RW = col * psum_bw;
    localparam logic [AW-1:0] LAST_ROW  = AW'(depth - 1);
    localparam logic [PW-1:0] LAST_PASS = PW'(passes - 1);

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [PW-1:0]   pass_q, pass_d;
    logic            out_valid_q, out_valid_d;
    logic            done_q, done_d;

    logic            pop;
    logic            handshake;
    logic            drd_en;
    logic [AW-1:0]   drd_addr;
    logic [RW-1:0]   acc_rd;
    logic [RW-1:0]   wr_dat;
    logic [RW-1:0]   drain_rd;
    logic [RW-1:0]   xform_dat;

    logic signed [psum_bw-1:0] col_a;
    logic signed [psum_bw-1:0] col_b;
    logic signed [31:0]        col_s;

    assign pop       = (state_q == ACC) && bus.ofifo_o_valid;
    assign handshake = (state_q == DRAIN) && out_valid_q && bus.out_ready;

    always_comb begin
        wr_dat = '0;
        col_a  = '0;
        col_b  = '0;
        col_s  = '0;
        for (int c = 0; c < col; c++) begin
            col_a = acc_rd[c*psum_bw +: psum_bw];
            col_b = bus.ofifo_out[c*psum_bw +: psum_bw];
            col_s = sat_add(32'(col_a), 32'(col_b), psum_bw);
            wr_dat[c*psum_bw +: psum_bw] = (pass_q == '0) ? col_b : col_s[psum_bw-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pass_d      = pass_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        drd_en      = 1'b0;
        drd_addr    = addr_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ACC;
                    addr_d  = '0;
                    pass_d  = '0;
                end
            end
            ACC: begin
                if (pop) begin
                    if (addr_q == LAST_ROW) begin
                        addr_d = '0;
                        if (pass_q == LAST_PASS) begin
                            // Prefetch row 0 so out_data is valid on the entry edge.
                            state_d     = DRAIN;
                            out_valid_d = 1'b1;
                            drd_en      = 1'b1;
                            drd_addr    = '0;
                        end else begin
                            pass_d = pass_q + PW'(1);
                        end
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            DRAIN: begin
                if (handshake) begin
                    if (addr_q == LAST_ROW) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                        addr_d      = '0;
                    end else begin
                        addr_d   = addr_q + AW'(1);
                        drd_en   = 1'b1;
                        drd_addr = addr_q + AW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            pass_q      <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pass_q      <= pass_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    psum_bank #(
        .width (RW),
        .depth (depth),
        .aw    (AW)
    ) u_bank (
        .clk      (clk),
        .reset    (reset),
        .we       (pop),
        .wr_addr  (addr_q),
        .wr_dat   (wr_dat),
        .rd_addr  (addr_q),
        .rd_dat   (acc_rd),
        .drd_en   (drd_en),
        .drd_addr (drd_addr),
        .drd_dat  (drain_rd)
    );

`ifdef PSUM_ACC_RELU_EN
    always_comb begin
        xform_dat = drain_rd;
        for (int c = 0; c < col; c++) begin
            if (drain_rd[c*psum_bw + psum_bw - 1]) begin
                xform_dat[c*psum_bw +: psum_bw] = '0;
            end
        end
    end
`else
    assign xform_dat = drain_rd;
`endif

    assign bus.ofifo_rd  = pop;
    assign bus.out_data  = xform_dat;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;

endmodule

// File: doc/psum_acc.md
# psum_acc

Output-side accumulation stage placed directly downstream of the corelet's output FIFO. It pops one row of `col` partial sums per cycle from the OFIFO and adds it into an internal bank of `depth` rows. It repeats this over `passes` kernel passes, one pass per kernel tap. After the final pass it drains the accumulated rows (optionally ReLU'd) to the next stage with a valid/ready handshake.

## Interface
Parameters:
- `col`, 8, number of columns (psums per row)
- `psum_bw`, 16, signed psum width
- `depth`, 16, output rows per pass (output pixels)
- `passes`, 9, kernel passes accumulated before drain

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse that begins a job; ignored unless IDLE
- `ofifo_o_valid`  in  1  OFIFO has a row available (show-ahead)
- `ofifo_out`  in  col*psum_bw  OFIFO head row; column c at bits [c*psum_bw +: psum_bw]
- `ofifo_rd`  out  1  pop strobe to the OFIFO
- `out_data`  out  col*psum_bw  drained row, same packing as `ofifo_out`
- `out_valid`  out  1  `out_data` is valid
- `out_ready`  in  1  consumer accepts the row
- `busy`  out  1  high in ACC or DRAIN
- `done`  out  1  one-cycle pulse after the last row is accepted

## Operation
- FSM has three states: IDLE, ACC and DRAIN.
- IDLE -> ACC on `start`.
  - Clears the row counter `addr` and the pass counter `pass`.
  - Bank content is not cleared; pass 0 overwrites it instead.
- ACC:
  - `ofifo_rd = ofifo_o_valid`.
  - On each pop, bank[addr] gets `ofifo_out` if `pass == 0`, else bank[addr] + `ofifo_out`.
  - Then `addr` increments. When `addr` wraps from depth-1 to 0, `pass` increments.
  - Pop of row depth-1 on pass passes-1 -> DRAIN, with `addr` = 0.
  - A stalled OFIFO (`ofifo_o_valid` low) causes no change.
- Arithmetic is per column, signed, in `psum_bw` bits with saturation: overflow gives 2^(psum_bw-1)-1, underflow gives -2^(psum_bw-1). There is no wrap.
- DRAIN:
  - `out_data` is bank[addr] after the output transform (see Configuration).
  - `out_valid` is high throughout DRAIN.
  - On a cycle with `out_valid && out_ready`, `addr` increments.
  - Acceptance of row depth-1 -> IDLE, with a `done` pulse in the following cycle.
- `start` while busy is ignored.
- `ofifo_rd` is never asserted outside ACC.

## Timing
- Reset values: `ofifo_rd` = 0, `out_valid` = 0, `out_data` = 0, `busy` = 0, `done` = 0; state = IDLE; counters = 0.
- `ofifo_rd` is combinational from state and `ofifo_o_valid`. The OFIFO pops on the same edge that writes the bank.
- ACC throughput is one row per cycle. Minimum ACC duration is depth*passes cycles.
- DRAIN output is registered.
  - `out_data` and `out_valid` are set on the edge entering DRAIN, one cycle after the last pop.
  - With `out_ready` held high, one row is emitted per cycle; the full drain takes depth cycles.
- `out_data` is held stable while `out_valid && !out_ready`.
- `done` goes high one cycle after the final handshake and lasts exactly one cycle. `busy` falls on that same edge.
- Reset asserted mid-job returns to IDLE immediately (asynchronously) and all outputs go to their reset values. No partial drain is resumed.

## Configuration
- Macro `PSUM_ACC_RELU_EN`:
  - Defined: each drained column is max(value, 0).
  - Undefined: drained values pass through unchanged.
- Accumulation is identical in both builds.

## Structure
- Shared package holds:
  - state enum: IDLE = 2'd0, ACC = 2'd1, DRAIN = 2'd2
  - per-column saturating-add function
  - `PSUM_MAX` and `PSUM_MIN` constants derived from `psum_bw`
- One sub-module: `psum_bank`, a `depth` x `col*psum_bw` register file.
  - Single write port.
  - One combinational read port for the accumulate read.
  - Registered drain read.
- FSM, counters and datapath stay in `psum_acc`.

## Test plan
- Basic: depth = 4, passes = 2, OFIFO always valid. Every column of every row is 1 on both passes -> 4 rows all equal to 2, exactly 8 pops, `done` pulse.
- Stalls: `ofifo_o_valid` toggles randomly. Pass p supplies row value p+3 -> each output column = 3+4 = 7; no pop while `ofifo_o_valid` is low.
- Backpressure: `out_ready` low for 5 cycles mid-drain -> `out_data` held constant, no row lost or duplicated.
- Saturation: column 0 receives 30000 on both passes -> 32767; column 1 receives -30000 on both passes -> -32768.
- ReLU: with `PSUM_ACC_RELU_EN`, a sum of -5 drains as 0. Without it, it drains as -5 (0xFFFB).
- Reset mid-ACC: reset pulled low after 3 pops -> `ofifo_rd` = 0 and `busy` = 0 immediately. A fresh job afterward produces correct sums with no residue from the aborted job.
